mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage controller that consumes the execute stage's results and drives the data-memory request/response protocol.
- Execute results come in as: ALU result used as address, srcB used as store data, memory write and register-source controls, and next PC.
- Sequences one access at a time to a multi-cycle data memory (request/stall/done handshake) and stalls the upstream pipeline meanwhile.
- Delivers a registered result to writeback.

Parameters:
- TIMEOUT_CYC, 64: max cycles in WAIT before the access is declared failed.
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage presents a valid instruction.
- ex_alu_out  in  16  ALU result; memory address for loads and stores.
- ex_srcb  in  16  store data.
- ex_next_PC  in  16  next PC, passed through to writeback.
- ex_memwrt  in  1  instruction is a store.
- ex_regsrc  in  1  instruction is a load; the writeback value comes from memory.
- mem_req  out  1  data-memory request.
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  16  access address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data; valid when mem_done=1.
- mem_stall  in  1  memory cannot accept the request this cycle.
- mem_done  in  1  access complete.
- stall  out  1  upstream must hold the ex_* inputs stable.
- wb_valid  out  1  single-cycle pulse: result available to writeback.
- wb_data  out  16  load data, or the ALU result for non-loads.
- wb_next_PC  out  16  next PC of the retiring instruction.
- err  out  1  sticky fault: misaligned access or timeout.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=IDLE;
  - mem_req, mem_wr, wb_valid, err = 0;
  - mem_addr, mem_wdata, wb_data, wb_next_PC = 0x0000;
  - timeout counter = 0.
- Reset mid-access: mem_req drops immediately, no writeback occurs, and the in-flight access is abandoned.
- States: IDLE, ISSUE, WAIT, ERR.
- stall = (state != IDLE); this is combinational from state. An instruction is accepted only in IDLE.
- IDLE, ex_valid=1, non-memory op (ex_memwrt=0, ex_regsrc=0):
  - next cycle: wb_valid=1, wb_data=ex_alu_out, wb_next_PC=ex_next_PC;
  - stay in IDLE. Latency is 1 cycle and there is no stall.
- IDLE, ex_valid=1, memory op, ex_alu_out[0]=1 (misaligned word access):
  - go to ERR; err=1 next cycle; no request issued.
- IDLE, ex_valid=1, aligned memory op:
  - register the address, the data, mem_wr=ex_memwrt and next_PC;
  - go to ISSUE with mem_req=1 from the next cycle.
- If both ex_memwrt and ex_regsrc are 1, the access is treated as a store.
- ISSUE: mem_req stays 1 and the outputs stay stable while mem_stall=1.
  - mem_stall=0 and mem_done=1 in the same cycle: the access completes in ISSUE.
  - mem_stall=0 and mem_done=0: go to WAIT, mem_req=0, timeout counter cleared.
- WAIT: mem_req=0; the counter increments each cycle.
  - mem_done=1: complete.
  - counter reaches TIMEOUT_CYC-1 without mem_done: go to ERR.
- Complete:
  - next cycle: wb_valid=1 for one cycle;
  - wb_data = mem_rdata for loads, or the registered address for stores;
  - state returns to IDLE, so stall deasserts in that same cycle.
- mem_done outside ISSUE/WAIT is ignored.
- ERR is terminal until reset:
  - err=1, stall=1, mem_req=0, wb_valid=0;
  - ex_* inputs are ignored.
- wb_data and wb_next_PC hold their last values when wb_valid=0.
- Arithmetic: no address computation in this block; addresses are passed verbatim. The counter saturates and does not wrap.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ERR=2'd3;
  - the 16-bit word-width constant.
- One natural sub-module: mem_timeout_cnt (clear/enable/saturating counter with terminal-count flag), instantiated once.
- Everything else is flat: FSM plus registered datapath.

Test Plan:
- Non-memory op: ex_valid=1, ex_alu_out=0x1234, ex_next_PC=0x0010, no mem controls -> next cycle wb_valid=1, wb_data=0x1234, wb_next_PC=0x0010; stall stays 0; mem_req never asserts.
- Load with 2 stall cycles and done 3 cycles later: ex_alu_out=0x0040, ex_regsrc=1, mem_rdata=0xBEEF -> mem_req=1 for 3 cycles with mem_addr=0x0040, mem_wr=0; stall=1 throughout; one wb_valid pulse with wb_data=0xBEEF; stall=0 in that same cycle.
- Store with zero-latency memory (mem_stall=0, mem_done=1 in ISSUE): ex_alu_out=0x0100, ex_srcb=0xA5A5 -> mem_wr=1, mem_wdata=0xA5A5 for one cycle; wb_valid next cycle with wb_data=0x0100.
- Misaligned access: ex_alu_out=0x0041, ex_memwrt=1 -> err=1 next cycle; mem_req stays 0; stall=1 persists; later ex_valid is ignored until rst=0.
- Timeout: load issued, mem_done never asserted -> err=1 after exactly TIMEOUT_CYC cycles in WAIT; no wb_valid.
- Asynchronous reset while in WAIT: rst=0 mid-cycle -> mem_req, stall, err, wb_valid = 0 immediately; after rst=1, a new non-memory op retires normally in 1 cycle.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_access_ctrl_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// Clearable saturating up-counter with a terminal-count flag.
module mem_timeout_cnt #(
    parameter int unsigned CNT_W  = 7,
    parameter int unsigned TC_VAL = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [CNT_W-1:0] cnt_q;

    assign tc_c = (cnt_q == CNT_W'(TC_VAL));

    // Holds at the terminal value instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: sequences one data-memory access at a time and
// delivers a registered result to writeback.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_alu_out,
    input  logic [WORD_W-1:0] ex_srcb,
    input  logic [WORD_W-1:0] ex_next_PC,
    input  logic              ex_memwrt,
    input  logic              ex_regsrc,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              mem_done,
    output logic              stall,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_data,
    output logic [WORD_W-1:0] wb_next_PC,
    output logic              err
);

    state_t            state_q, state_d;
    logic              mem_req_d, mem_wr_d, wb_valid_d, err_d;
    logic [WORD_W-1:0] addr_d, wdata_d, wb_data_d, wb_pc_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              cnt_clr, cnt_en, cnt_tc;
    logic              complete;

    assign stall = (state_q != IDLE);

    mem_timeout_cnt #(
        .CNT_W  (CNT_W),
        .TC_VAL (TIMEOUT_CYC - 1)
    ) u_timeout_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc_c (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = 1'b0;
        mem_wr_d   = mem_wr;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
        pc_d       = pc_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data;
        wb_pc_d    = wb_next_PC;
        err_d      = err;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        complete   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_memwrt || ex_regsrc) begin
                        if (ex_alu_out[0]) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d   = ISSUE;
                            mem_req_d = 1'b1;
                            mem_wr_d  = ex_memwrt;
                            addr_d    = ex_alu_out;
                            wdata_d   = ex_srcb;
                            pc_d      = ex_next_PC;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_out;
                        wb_pc_d    = ex_next_PC;
                    end
                end
            end
            ISSUE: begin
                if (mem_stall) begin
                    mem_req_d = 1'b1;
                end else if (mem_done) begin
                    complete = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_clr = 1'b1;
                end
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (mem_done) begin
                    complete = 1'b1;
                end else if (cnt_tc) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
            ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stores report their address; loads report the returned word.
        if (complete) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_data_d  = mem_wr ? mem_addr : mem_rdata;
            wb_pc_d    = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            pc_q       <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_next_PC <= '0;
            err        <= 1'b0;
        end else begin
            mem_req    <= mem_req_d;
            mem_wr     <= mem_wr_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            pc_q       <= pc_d;
            wb_valid   <= wb_valid_d;
            wb_data    <= wb_data_d;
            wb_next_PC <= wb_pc_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus multi-cycle sequences.
module tb_mem_access_ctrl;

    localparam int unsigned TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_srcb;
    logic [15:0] ex_next_PC;
    logic        ex_memwrt;
    logic        ex_regsrc;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_stall;
    logic        mem_done;
    logic        stall;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [15:0] wb_next_PC;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_ctrl #(
        .TIMEOUT_CYC (TIMEOUT),
        .CNT_W       (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_alu_out (ex_alu_out),
        .ex_srcb    (ex_srcb),
        .ex_next_PC (ex_next_PC),
        .ex_memwrt  (ex_memwrt),
        .ex_regsrc  (ex_regsrc),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_stall  (mem_stall),
        .mem_done   (mem_done),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_next_PC (wb_next_PC),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] alu;
        logic [15:0] pc;
        logic        exp_wbv;
        logic [15:0] exp_data;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [15:0] alu, input logic [15:0] srcb,
                            input logic [15:0] pc, input logic wr, input logic rs);
        ex_valid   = v;
        ex_alu_out = alu;
        ex_srcb    = srcb;
        ex_next_PC = pc;
        ex_memwrt  = wr;
        ex_regsrc  = rs;
    endtask

    // Called one time unit after a clock edge; asserts reset mid-cycle.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        chk({tag, "_req"},      16'(mem_req),  16'h0);
        chk({tag, "_stall"},    16'(stall),    16'h0);
        chk({tag, "_err"},      16'(err),      16'h0);
        chk({tag, "_wbv"},      16'(wb_valid), 16'h0);
        chk({tag, "_wb_data"},  wb_data,       16'h0000);
        #3 rst = 1'b1;
    endtask

    initial begin
        logic seen_bad;
        rst       = 1'b0;
        mem_rdata = 16'h0;
        mem_stall = 1'b0;
        mem_done  = 1'b0;
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

        vecs[0] = '{1'b1, 16'h1234, 16'h0010, 1'b1, 16'h1234, 16'h0010};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h1234, 16'h0010};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h0002, 1'b1, 16'hFFFF, 16'h0002};
        vecs[3] = '{1'b1, 16'h0001, 16'h8000, 1'b1, 16'h0001, 16'h8000};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0001, 16'h8000};

        #3;
        chk("rst_req",     16'(mem_req),  16'h0);
        chk("rst_wr",      16'(mem_wr),   16'h0);
        chk("rst_wbv",     16'(wb_valid), 16'h0);
        chk("rst_err",     16'(err),      16'h0);
        chk("rst_stall",   16'(stall),    16'h0);
        chk("rst_addr",    mem_addr,      16'h0000);
        chk("rst_wdata",   mem_wdata,     16'h0000);
        chk("rst_wb_data", wb_data,       16'h0000);
        chk("rst_wb_pc",   wb_next_PC,    16'h0000);
        #9 rst = 1'b1;

        // Non-memory ops retire in one cycle with no stall.
        for (int i = 0; i < 5; i++) begin
            drive_ex(vecs[i].v, vecs[i].alu, 16'h0, vecs[i].pc, 1'b0, 1'b0);
            step();
            chk($sformatf("vec%0d_wbv", i),   16'(wb_valid), 16'(vecs[i].exp_wbv));
            chk($sformatf("vec%0d_data", i),  wb_data,       vecs[i].exp_data);
            chk($sformatf("vec%0d_pc", i),    wb_next_PC,    vecs[i].exp_pc);
            chk($sformatf("vec%0d_stall", i), 16'(stall),    16'h0);
            chk($sformatf("vec%0d_req", i),   16'(mem_req),  16'h0);
            chk($sformatf("vec%0d_err", i),   16'(err),      16'h0);
        end

        // Stray mem_done while idle is ignored.
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        mem_done = 1'b1;
        step();
        chk("idle_done_wbv",   16'(wb_valid), 16'h0);
        chk("idle_done_stall", 16'(stall),    16'h0);
        mem_done = 1'b0;

        // Load: two stalled ISSUE cycles, accepted and completed in the third.
        drive_ex(1'b1, 16'h0040, 16'h0, 16'h0020, 1'b0, 1'b1);
        mem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("ld_req%0d", c),   16'(mem_req),  16'h1);
            chk($sformatf("ld_addr%0d", c),  mem_addr,      16'h0040);
            chk($sformatf("ld_wr%0d", c),    16'(mem_wr),   16'h0);
            chk($sformatf("ld_stall%0d", c), 16'(stall),    16'h1);
            chk($sformatf("ld_wbv%0d", c),   16'(wb_valid), 16'h0);
        end
        mem_stall = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_done  = 1'b0;
        mem_rdata = 16'h0;
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("ld_wbv",   16'(wb_valid), 16'h1);
        chk("ld_data",  wb_data,       16'hBEEF);
        chk("ld_pc",    wb_next_PC,    16'h0020);
        chk("ld_stall", 16'(stall),    16'h0);
        chk("ld_req",   16'(mem_req),  16'h0);
        step();
        chk("ld_wbv_pulse", 16'(wb_valid), 16'h0);
        chk("ld_data_hold", wb_data,       16'hBEEF);

        // Store against a zero-latency memory.
        drive_ex(1'b1, 16'h0100, 16'hA5A5, 16'h0030, 1'b1, 1'b0);
        step();
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("st_req",   16'(mem_req), 16'h1);
        chk("st_wr",    16'(mem_wr),  16'h1);
        chk("st_wdata", mem_wdata,    16'hA5A5);
        chk("st_addr",  mem_addr,     16'h0100);
        mem_done  = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_done = 1'b0;
        chk("st_wbv",   16'(wb_valid), 16'h1);
        chk("st_data",  wb_data,       16'h0100);
        chk("st_pc",    wb_next_PC,    16'h0030);
        chk("st_req_0", 16'(mem_req),  16'h0);
        chk("st_stall", 16'(stall),    16'h0);
        step();
        chk("st_wbv_pulse", 16'(wb_valid), 16'h0);

        // Both controls set behaves as a store.
        drive_ex(1'b1, 16'h0300, 16'h7777, 16'h0034, 1'b1, 1'b1);
        step();
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("both_wr", 16'(mem_wr), 16'h1);
        mem_done = 1'b1;
        step();
        mem_done  = 1'b0;
        mem_rdata = 16'h0;
        chk("both_wbv",  16'(wb_valid), 16'h1);
        chk("both_data", wb_data,       16'h0300);

        // Misaligned access faults without a request and ignores later ops.
        drive_ex(1'b1, 16'h0041, 16'h0, 16'h0038, 1'b1, 1'b0);
        step();
        chk("mis_err",   16'(err),     16'h1);
        chk("mis_req",   16'(mem_req), 16'h0);
        chk("mis_stall", 16'(stall),   16'h1);
        drive_ex(1'b1, 16'h5555, 16'h0, 16'h0040, 1'b0, 1'b0);
        seen_bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (wb_valid || mem_req || !err || !stall) seen_bad = 1'b1;
        end
        chk("mis_sticky", 16'(seen_bad), 16'h0);
        chk("mis_wb_data_hold", wb_data, 16'h0300);
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        async_reset("mis_rst");

        // Timeout: load never completes.
        drive_ex(1'b1, 16'h0200, 16'h0, 16'h0050, 1'b0, 1'b1);
        step();
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("to_req_issue", 16'(mem_req), 16'h1);
        step();
        chk("to_req_wait", 16'(mem_req), 16'h0);
        chk("to_stall",    16'(stall),   16'h1);
        seen_bad = 1'b0;
        for (int c = 0; c < int'(TIMEOUT) - 1; c++) begin
            step();
            if (err || wb_valid || mem_req || !stall) seen_bad = 1'b1;
        end
        chk("to_early", 16'(seen_bad), 16'h0);
        step();
        chk("to_err",   16'(err),      16'h1);
        chk("to_stall_err", 16'(stall), 16'h1);
        chk("to_wbv",   16'(wb_valid), 16'h0);
        async_reset("to_rst");

        // Reset with a request outstanding in ISSUE.
        drive_ex(1'b1, 16'h0400, 16'h0, 16'h0060, 1'b0, 1'b1);
        mem_stall = 1'b1;
        step();
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("iss_req", 16'(mem_req), 16'h1);
        async_reset("iss_rst");
        mem_stall = 1'b0;

        // Reset in WAIT, then a fresh non-memory op.
        drive_ex(1'b1, 16'h0402, 16'h0, 16'h0064, 1'b0, 1'b1);
        step();
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();
        step();
        chk("wait_stall", 16'(stall), 16'h1);
        async_reset("wait_rst");
        step();
        chk("post_rst_wbv", 16'(wb_valid), 16'h0);
        drive_ex(1'b1, 16'h4321, 16'h0, 16'h0044, 1'b0, 1'b0);
        step();
        drive_ex(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("post_rst_wbv1", 16'(wb_valid), 16'h1);
        chk("post_rst_data", wb_data,       16'h4321);
        chk("post_rst_pc",   wb_next_PC,    16'h0044);
        chk("post_rst_stall", 16'(stall),   16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
